// File: rtl/i2c_state_pkg.sv
// Shared types for the I2C register arbiter.
//   arb_state_t  : one-hot arbiter state, with matching bit-index constants
//   owner_t      : which requester was granted the bank most recently
package i2c_state_pkg;

  localparam int unsigned ARB_IDLE_BIT      = 0;
  localparam int unsigned ARB_I2C_ISSUE_BIT = 1;
  localparam int unsigned ARB_I2C_RESP_BIT  = 2;
  localparam int unsigned ARB_LOC_ISSUE_BIT = 3;
  localparam int unsigned ARB_LOC_RESP_BIT  = 4;

  typedef enum logic [4:0] {
    ARB_IDLE      = 5'b00001,
    ARB_I2C_ISSUE = 5'b00010,
    ARB_I2C_RESP  = 5'b00100,
    ARB_LOC_ISSUE = 5'b01000,
    ARB_LOC_RESP  = 5'b10000
  } arb_state_t;

  typedef enum logic {
    OWNER_I2C   = 1'b0,
    OWNER_LOCAL = 1'b1
  } owner_t;

endpackage

// File: rtl/i2c_req_capture.sv
// I2C-side request capture: pointer phase, single pending request latch and overrun flag.
// Ports:
//   clk, rst_n                 : system clock, async active-low reset
//   i2c_start/stop             : bus condition pulses (win over same-cycle byte/read pulses)
//   i2c_wr_vld, i2c_wr_byte    : received byte pulse and data
//   i2c_rd_req                 : transmit-byte request pulse
//   i2c_busy                   : an I2C bank op is in flight (issue or response cycle)
//   i2c_issue                  : the pending request is being issued this cycle
//   ptr_load, ptr_load_val     : first byte after START loads the register pointer
//   pend, pend_we, pend_wdata  : pending request and its latched type/data
//   overrun                    : sticky, request arrived while one was pending/in flight
module i2c_req_capture #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2c_start,
  input  logic              i2c_stop,
  input  logic              i2c_wr_vld,
  input  logic [7:0]        i2c_wr_byte,
  input  logic              i2c_rd_req,
  input  logic              i2c_busy,
  input  logic              i2c_issue,
  output logic              ptr_load,
  output logic [ADDR_W-1:0] ptr_load_val,
  output logic              pend,
  output logic              pend_we,
  output logic [7:0]        pend_wdata,
  output logic              overrun
);

  logic       phase_q, phase_d;
  logic       pend_q, pend_d;
  logic       we_q, we_d;
  logic [7:0] wdata_q, wdata_d;
  logic       ovr_q, ovr_d;

  always_comb begin
    phase_d  = phase_q;
    pend_d   = pend_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    ovr_d    = ovr_q;
    ptr_load = 1'b0;
    if (i2c_start || i2c_stop) begin
      // Bus conditions discard any unissued request; an issued op finishes on its own.
      phase_d = i2c_start;
      pend_d  = 1'b0;
    end else begin
      if (i2c_issue) pend_d = 1'b0;
      if (i2c_wr_vld && phase_q) begin
        ptr_load = 1'b1;
        phase_d  = 1'b0;
      end else if (i2c_wr_vld || i2c_rd_req) begin
        if (pend_q || i2c_busy) begin
          ovr_d = 1'b1;
        end else begin
          pend_d  = 1'b1;
          we_d    = i2c_wr_vld;
          wdata_d = i2c_wr_byte;
          // A read straight after START is a current-address read.
          phase_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
      ovr_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pend_q  <= pend_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ptr_load_val = ADDR_W'(i2c_wr_byte);
  assign pend         = pend_q;
  assign pend_we      = we_q;
  assign pend_wdata   = wdata_q;
  assign overrun      = ovr_q;

endmodule

// File: rtl/i2c_reg_arbiter.sv
// Shares a single-port register bank between the I2C subordinate byte interface and a local
// host port. Round-robin on conflict; SCL is stretched while an I2C request waits or is served.
// Ports:
//   clk, rst_n                          : system clock, async active-low reset
//   i2c_start/stop/wr_vld/wr_byte/rd_req: synchronised single-cycle I2C-side pulses
//   i2c_rd_byte, i2c_rd_vld             : registered transmit byte and its update pulse
//   hold_clock_low                      : request SCL stretch
//   i2c_overrun                         : sticky request-while-busy flag
//   loc_req/we/addr/wdata               : local request, held until loc_done
//   loc_gnt, loc_done, loc_rdata        : local issue pulse, completion pulse, read data
//   reg_en/we/addr/wdata, reg_rdata     : bank port; read data valid the cycle after reg_en
module i2c_reg_arbiter
  import i2c_state_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2c_start,
  input  logic              i2c_stop,
  input  logic              i2c_wr_vld,
  input  logic [7:0]        i2c_wr_byte,
  input  logic              i2c_rd_req,
  output logic [7:0]        i2c_rd_byte,
  output logic              i2c_rd_vld,
  output logic              hold_clock_low,
  output logic              i2c_overrun,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  output logic              loc_gnt,
  output logic              loc_done,
  output logic [7:0]        loc_rdata,
  output logic              reg_en,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              op_we_q, op_we_d;
  logic [7:0]        rd_byte_q, rd_byte_d;
  logic              rd_vld_q, rd_vld_d;

  logic              ptr_load;
  logic [ADDR_W-1:0] ptr_load_val;
  logic              pend, pend_we, pend_live;
  logic [7:0]        pend_wdata;
  logic              i2c_busy, i2c_issue;

  assign i2c_issue = state_q[ARB_I2C_ISSUE_BIT];
  assign i2c_busy  = state_q[ARB_I2C_ISSUE_BIT] | state_q[ARB_I2C_RESP_BIT];
  // A START/STOP this cycle kills the pending request, so don't commit to issuing it.
  assign pend_live = pend & ~(i2c_start | i2c_stop);

  i2c_req_capture #(
    .ADDR_W (ADDR_W)
  ) u_capture (
    .clk          (clk),
    .rst_n        (rst_n),
    .i2c_start    (i2c_start),
    .i2c_stop     (i2c_stop),
    .i2c_wr_vld   (i2c_wr_vld),
    .i2c_wr_byte  (i2c_wr_byte),
    .i2c_rd_req   (i2c_rd_req),
    .i2c_busy     (i2c_busy),
    .i2c_issue    (i2c_issue),
    .ptr_load     (ptr_load),
    .ptr_load_val (ptr_load_val),
    .pend         (pend),
    .pend_we      (pend_we),
    .pend_wdata   (pend_wdata),
    .overrun      (i2c_overrun)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    op_we_d   = op_we_q;
    rd_byte_d = rd_byte_q;
    rd_vld_d  = 1'b0;
    reg_en    = 1'b0;
    reg_we    = 1'b0;
    reg_addr  = '0;
    reg_wdata = 8'h00;
    loc_gnt   = 1'b0;
    loc_done  = 1'b0;
    loc_rdata = 8'h00;
    if (ptr_load) ptr_d = ptr_load_val;
    unique case (state_q)
      ARB_IDLE: begin
        if (pend_live && (!loc_req || owner_q == OWNER_LOCAL)) begin
          state_d = ARB_I2C_ISSUE;
        end else if (loc_req) begin
          state_d = ARB_LOC_ISSUE;
        end
      end
      ARB_I2C_ISSUE: begin
        reg_en    = 1'b1;
        reg_we    = pend_we;
        reg_addr  = ptr_q;
        reg_wdata = pend_we ? pend_wdata : 8'h00;
        if (!ptr_load) ptr_d = ptr_q + ADDR_W'(1);
        owner_d   = OWNER_I2C;
        op_we_d   = pend_we;
        state_d   = ARB_I2C_RESP;
      end
      ARB_I2C_RESP: begin
        if (!op_we_q) begin
          rd_byte_d = reg_rdata;
          rd_vld_d  = 1'b1;
        end
        state_d = ARB_IDLE;
      end
      ARB_LOC_ISSUE: begin
        reg_en    = 1'b1;
        reg_we    = loc_we;
        reg_addr  = loc_addr;
        reg_wdata = loc_wdata;
        loc_gnt   = 1'b1;
        owner_d   = OWNER_LOCAL;
        op_we_d   = loc_we;
        state_d   = ARB_LOC_RESP;
      end
      ARB_LOC_RESP: begin
        loc_done  = 1'b1;
        loc_rdata = op_we_q ? 8'h00 : reg_rdata;
        state_d   = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWNER_LOCAL;
      ptr_q     <= '0;
      op_we_q   <= 1'b0;
      rd_byte_q <= 8'h00;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      op_we_q   <= op_we_d;
      rd_byte_q <= rd_byte_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign i2c_rd_byte    = rd_byte_q;
  assign i2c_rd_vld     = rd_vld_q;
  assign hold_clock_low = pend | i2c_busy;

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Bench for i2c_reg_arbiter: directed timing scenarios plus randomized concurrent I2C/local
// traffic checked against a transaction-level bank model.
module tb_i2c_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i2c_start = 1'b0, i2c_stop = 1'b0, i2c_wr_vld = 1'b0, i2c_rd_req = 1'b0;
  logic [7:0] i2c_wr_byte = 8'h00;
  logic [7:0] i2c_rd_byte;
  logic       i2c_rd_vld, hold_clock_low, i2c_overrun;
  logic       loc_req = 1'b0, loc_we = 1'b0;
  logic [7:0] loc_addr = 8'h00, loc_wdata = 8'h00;
  logic       loc_gnt, loc_done;
  logic [7:0] loc_rdata;
  logic       reg_en, reg_we;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata;

  always #5 clk = ~clk;

  i2c_reg_arbiter #(
    .ADDR_W (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i2c_start      (i2c_start),
    .i2c_stop       (i2c_stop),
    .i2c_wr_vld     (i2c_wr_vld),
    .i2c_wr_byte    (i2c_wr_byte),
    .i2c_rd_req     (i2c_rd_req),
    .i2c_rd_byte    (i2c_rd_byte),
    .i2c_rd_vld     (i2c_rd_vld),
    .hold_clock_low (hold_clock_low),
    .i2c_overrun    (i2c_overrun),
    .loc_req        (loc_req),
    .loc_we         (loc_we),
    .loc_addr       (loc_addr),
    .loc_wdata      (loc_wdata),
    .loc_gnt        (loc_gnt),
    .loc_done       (loc_done),
    .loc_rdata      (loc_rdata),
    .reg_en         (reg_en),
    .reg_we         (reg_we),
    .reg_addr       (reg_addr),
    .reg_wdata      (reg_wdata),
    .reg_rdata      (reg_rdata)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Register bank attached to the DUT.
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    reg_rdata <= 8'h00;
    forever begin
      @(posedge clk);
      if (reg_en) begin
        if (reg_we) mem[reg_addr] <= reg_wdata;
        else        reg_rdata     <= mem[reg_addr];
      end
    end
  end

  // Activity monitor: bank strobes, grant order (1 = local), completions.
  int   en_cnt = 0, done_cnt = 0, consec = 0;
  logic en_prev = 1'b0;
  logic gq [$];
  always @(negedge clk) begin
    if (reg_en) begin
      en_cnt <= en_cnt + 1;
      gq.push_back(loc_gnt);
      if (en_prev) consec <= consec + 1;
    end
    en_prev <= reg_en;
    if (loc_done) done_cnt <= done_cnt + 1;
  end

  // Reference model: expected bank contents and I2C pointer state.
  logic [7:0] mem_ref [256];
  logic [7:0] ptr_ref = 8'h00;
  logic       phase_ref = 1'b0;

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (hold_clock_low && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check({tag, "_hold_timeout"}, 64'(hold_clock_low), 64'd0);
  endtask

  task automatic i2c_start_p();
    i2c_start = 1'b1;
    tick();
    i2c_start = 1'b0;
    phase_ref = 1'b1;
  endtask

  task automatic i2c_stop_p();
    i2c_stop = 1'b1;
    tick();
    i2c_stop = 1'b0;
    phase_ref = 1'b0;
  endtask

  task automatic i2c_wr(input logic [7:0] b);
    i2c_wr_byte = b;
    i2c_wr_vld  = 1'b1;
    tick();
    i2c_wr_vld  = 1'b0;
    if (phase_ref) begin
      ptr_ref   = b;
      phase_ref = 1'b0;
    end else begin
      mem_ref[ptr_ref] = b;
      ptr_ref++;
    end
    wait_idle("i2c_wr");
  endtask

  task automatic i2c_rd(input string tag);
    int n = 0;
    i2c_rd_req = 1'b1;
    tick();
    i2c_rd_req = 1'b0;
    while (!i2c_rd_vld && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, 64'(i2c_rd_vld), 64'd1);
    check(tag, 64'(i2c_rd_byte), 64'(mem_ref[ptr_ref]));
    ptr_ref++;
    phase_ref = 1'b0;
  endtask

  task automatic loc_op(input logic we, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    loc_we = we; loc_addr = a; loc_wdata = d; loc_req = 1'b1;
    do begin
      tick();
      n++;
    end while (!loc_done && n < 40);
    check("loc_done_seen", 64'(loc_done), 64'd1);
    if (we) begin
      check("loc_wr_rdata", 64'(loc_rdata), 64'd0);
      mem_ref[a] = d;
    end else begin
      check("loc_rd_data", 64'(loc_rdata), 64'(mem_ref[a]));
    end
    loc_req = 1'b0;
    tick();
  endtask

  // I2C traffic stays in 0x00-0x7F, local in 0x80-0xFF, so concurrent order doesn't matter.
  task automatic i2c_write_txn();
    int nb = $urandom_range(4, 1);
    i2c_start_p();
    i2c_wr(8'($urandom_range(8'h7b, 0)));
    for (int j = 0; j < nb; j++) i2c_wr(8'($urandom));
    i2c_stop_p();
  endtask

  task automatic i2c_read_txn();
    int nb = $urandom_range(4, 1);
    i2c_start_p();
    i2c_wr(8'($urandom_range(8'h7b, 0)));
    i2c_start_p();
    for (int j = 0; j < nb; j++) i2c_rd("rnd_i2c_rd");
    i2c_stop_p();
  endtask

  task automatic rand_round();
    fork
      begin
        if ($urandom_range(1, 0) == 1) i2c_write_txn();
        else i2c_read_txn();
      end
      begin
        int k = $urandom_range(2, 0);
        for (int j = 0; j < k; j++)
          loc_op(1'($urandom_range(1, 0)), 8'h80 | 8'($urandom_range(127, 0)), 8'($urandom));
      end
    join
  endtask

  function automatic int bank_mismatches();
    int c = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mem_ref[i]) c++;
    return c;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         e0, d0, g0, ni, nl, ii;
    logic [7:0] x, y, w;
    for (int i = 0; i < 256; i++) mem_ref[i] = init_val(i);
    repeat (3) tick();
    check("rst_outs_i2c", {i2c_rd_byte, i2c_rd_vld, hold_clock_low, i2c_overrun}, 64'd0);
    check("rst_outs_loc", {loc_gnt, loc_done, loc_rdata, reg_en, reg_we, reg_addr, reg_wdata},
          64'd0);
    rst_n = 1'b1;
    tick();

    // Local write then a timed local read of 0x10.
    loc_op(1'b1, 8'h10, 8'h77);
    loc_we = 1'b0; loc_addr = 8'h10; loc_req = 1'b1;
    tick();
    check("loc_lat_gnt", {loc_gnt, reg_en, reg_we, reg_addr}, {1'b1, 1'b1, 1'b0, 8'h10});
    tick();
    check("loc_lat_done", {loc_done, loc_rdata, reg_en}, {1'b1, 8'h77, 1'b0});
    loc_req = 1'b0;
    tick();

    // Burst write from pointer 5.
    i2c_start_p();
    e0 = en_cnt;
    i2c_wr(8'h05);
    i2c_wr(8'ha5);
    i2c_wr(8'h3c);
    check("s1_bank5", 64'(mem[5]), 64'ha5);
    check("s1_bank6", 64'(mem[6]), 64'h3c);
    check("s1_en_pulses", 64'(en_cnt - e0), 64'd2);

    // Timed current-address read: proves the pointer landed on 7.
    i2c_start_p();
    i2c_rd_req = 1'b1;
    tick();
    i2c_rd_req = 1'b0;
    check("cur_rd_c1", {hold_clock_low, reg_en}, {1'b1, 1'b0});
    tick();
    check("cur_rd_c2", {reg_en, reg_we, reg_addr}, {1'b1, 1'b0, 8'h07});
    tick();
    check("cur_rd_c3", {i2c_rd_vld, hold_clock_low}, {1'b0, 1'b1});
    tick();
    check("cur_rd_c4", {i2c_rd_vld, i2c_rd_byte}, {1'b1, init_val(7)});
    ptr_ref = 8'h08;
    phase_ref = 1'b0;
    i2c_stop_p();

    // Pointer wrap.
    i2c_start_p();
    i2c_wr(8'hff);
    i2c_wr(8'h11);
    i2c_wr(8'h22);
    i2c_stop_p();
    check("wrap_bank_ff", 64'(mem[255]), 64'h11);
    check("wrap_bank_00", 64'(mem[0]), 64'h22);

    // I2C read arriving while a local read is in flight.
    i2c_start_p();
    i2c_wr(8'h40);
    loc_we = 1'b0; loc_addr = 8'h10; loc_req = 1'b1;
    tick();
    i2c_rd_req = 1'b1;
    tick();
    i2c_rd_req = 1'b0;
    check("mix_loc_done", {loc_done, loc_rdata, hold_clock_low}, {1'b1, 8'h77, 1'b1});
    loc_req = 1'b0;
    tick();
    check("mix_wait", {hold_clock_low, reg_en}, {1'b1, 1'b0});
    tick();
    check("mix_issue", {reg_en, reg_we, reg_addr, hold_clock_low}, {1'b1, 1'b0, 8'h40, 1'b1});
    tick();
    tick();
    check("mix_rd_vld", {i2c_rd_vld, i2c_rd_byte}, {1'b1, mem_ref[8'h40]});
    ptr_ref = 8'h41;
    i2c_stop_p();

    // Randomized concurrent traffic.
    repeat (30) rand_round();
    check("rnd_bank_mismatches", 64'(bank_mismatches()), 64'd0);

    // Local requester never lets go while I2C writes a byte every 6 cycles.
    i2c_start_p();
    i2c_wr(8'h50);
    g0 = gq.size();
    loc_we = 1'b0; loc_addr = 8'hc0; loc_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      x = 8'($urandom);
      i2c_wr_byte = x;
      i2c_wr_vld  = 1'b1;
      tick();
      i2c_wr_vld  = 1'b0;
      mem_ref[ptr_ref] = x;
      ptr_ref++;
      repeat (5) tick();
    end
    loc_req = 1'b0;
    repeat (4) tick();
    wait_idle("alt");
    i2c_stop_p();
    ni = 0; nl = 0; ii = 0;
    for (int i = g0; i < gq.size(); i++) begin
      if (gq[i]) nl++;
      else begin
        ni++;
        if (i > g0 && !gq[i-1]) ii++;
      end
    end
    check("alt_i2c_grants", 64'(ni), 64'd10);
    check("alt_i2c_back_to_back", 64'(ii), 64'd0);
    check("alt_loc_not_starved", 64'(nl >= 10), 64'd1);
    check("alt_bank_mismatches", 64'(bank_mismatches()), 64'd0);

    // Second write while the first is still pending is dropped.
    i2c_start_p();
    i2c_wr(8'h30);
    check("ovr_clear_before", 64'(i2c_overrun), 64'd0);
    x = 8'($urandom); y = 8'($urandom); w = 8'($urandom);
    loc_we = 1'b1; loc_addr = 8'h90; loc_wdata = w; loc_req = 1'b1;
    tick();
    i2c_wr_byte = x; i2c_wr_vld = 1'b1;
    tick();
    i2c_wr_vld = 1'b0; loc_req = 1'b0;
    mem_ref[8'h90] = w;
    tick();
    i2c_wr_byte = y; i2c_wr_vld = 1'b1;
    tick();
    i2c_wr_vld = 1'b0;
    check("ovr_set", 64'(i2c_overrun), 64'd1);
    wait_idle("ovr");
    mem_ref[8'h30] = x;
    ptr_ref = 8'h31;
    check("ovr_first_written", 64'(mem[8'h30]), 64'(x));
    check("ovr_second_dropped", 64'(mem[8'h31]), 64'(mem_ref[8'h31]));
    i2c_stop_p();

    // STOP cancels a write that is still waiting for the bank.
    i2c_start_p();
    i2c_wr(8'h60);
    loc_we = 1'b0; loc_addr = 8'h90; loc_req = 1'b1;
    tick();
    i2c_wr_byte = 8'h5a; i2c_wr_vld = 1'b1;
    tick();
    i2c_wr_vld = 1'b0; loc_req = 1'b0;
    check("stop_hold_pending", 64'(hold_clock_low), 64'd1);
    e0 = en_cnt;
    i2c_stop_p();
    check("stop_hold_dropped", 64'(hold_clock_low), 64'd0);
    repeat (4) tick();
    check("stop_no_access", 64'(en_cnt - e0), 64'd0);
    check("final_bank_mismatches", 64'(bank_mismatches()), 64'd0);

    // Reset during the local response cycle abandons the access.
    d0 = done_cnt;
    loc_we = 1'b0; loc_addr = 8'h10; loc_req = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    loc_req = 1'b0;
    #1;
    check("rst_mid_outs_i2c", {i2c_rd_byte, i2c_rd_vld, hold_clock_low, i2c_overrun}, 64'd0);
    check("rst_mid_outs_loc",
          {loc_gnt, loc_done, loc_rdata, reg_en, reg_we, reg_addr, reg_wdata}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);

    check("reg_en_back_to_back", 64'(consec), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
